// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline stage with a two-entry skid buffer (main M, skid S), valid/ready on both sides,
// registered branch-mispredict flag and a saturating mispredict counter.
module ex_mem_skid_stage #(
    parameter int unsigned CONTROL_LINE     = 5,
    parameter int unsigned DATA_LEN         = 64,
    parameter int unsigned INSTRUCTION_PART = 5,
    parameter int unsigned CNT_W            = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        if_beq,
    input  logic [DATA_LEN-1:0]         alu_val,
    input  logic [DATA_LEN-1:0]         wr_addr,
    input  logic [INSTRUCTION_PART-1:0] instruction_part,
    input  logic [CONTROL_LINE-1:0]     control_in,
    input  logic                        zero_in,
    input  logic                        predictor_val,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        if_beq_out,
    output logic [DATA_LEN-1:0]         alu_val_out,
    output logic [DATA_LEN-1:0]         wr_addr_out,
    output logic [INSTRUCTION_PART-1:0] instruction_part_out,
    output logic [CONTROL_LINE-1:0]     control_out,
    output logic                        zero_out,
    output logic                        predictor_out,
    output logic                        mispredict_out,
    output logic [CNT_W-1:0]            mispredict_cnt
);

    typedef struct packed {
        logic                        if_beq;
        logic [DATA_LEN-1:0]         alu_val;
        logic [DATA_LEN-1:0]         wr_addr;
        logic [INSTRUCTION_PART-1:0] rd;
        logic [CONTROL_LINE-1:0]     control;
        logic                        zero;
        logic                        predictor;
    } entry_t;

    entry_t           m_q, m_d, s_q, s_d, in_entry;
    logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc, ret, mispredict;

    assign in_entry = '{if_beq:    if_beq,
                        alu_val:   alu_val,
                        wr_addr:   wr_addr,
                        rd:        instruction_part,
                        control:   control_in,
                        zero:      zero_in,
                        predictor: predictor_val};

    // An input offered during flush is dropped even when in_ready is high.
    assign acc        = in_valid & in_ready_q & ~flush;
    assign ret        = m_valid_q & out_ready;
    assign mispredict = m_valid_q & m_q.if_beq & (m_q.zero ^ m_q.predictor);

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d     = 1'b0;
            s_valid_d     = 1'b0;
            m_d           = '0;
            s_d           = '0;
            // Legacy behaviour: flush toggles the stored predictor bit instead of clearing it.
            m_d.predictor = ~m_q.predictor;
            s_d.predictor = ~s_q.predictor;
        end else begin
            case ({m_valid_q, s_valid_q})
                2'b00: begin
                    if (acc) begin
                        m_d       = in_entry;
                        m_valid_d = 1'b1;
                    end
                end
                2'b10: begin
                    if (acc && ret) begin
                        m_d = in_entry;
                    end else if (acc) begin
                        s_d       = in_entry;
                        s_valid_d = 1'b1;
                    end else if (ret) begin
                        m_valid_d = 1'b0;
                    end
                end
                2'b11: begin
                    if (ret) begin
                        m_d       = s_q;
                        s_valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (ret && mispredict && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q        <= '0;
            s_q        <= '0;
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            m_q        <= m_d;
            s_q        <= s_d;
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            // Registered so MEM's ready never reaches EX combinationally.
            in_ready_q <= ~s_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready             = in_ready_q;
    assign out_valid            = m_valid_q;
    assign if_beq_out           = m_q.if_beq;
    assign alu_val_out          = m_q.alu_val;
    assign wr_addr_out          = m_q.wr_addr;
    assign instruction_part_out = m_q.rd;
    assign control_out          = m_q.control;
    assign zero_out             = m_q.zero;
    assign predictor_out        = m_q.predictor;
    assign mispredict_out       = mispredict;
    assign mispredict_cnt       = cnt_q;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Bench for ex_mem_skid_stage: scenario tasks plus a negedge scoreboard that tracks accepted
// bundles and the mispredict counters for a default instance and a 2-bit-counter instance.
module tb_ex_mem_skid_stage;

    typedef struct packed {
        logic        if_beq;
        logic [63:0] alu_val;
        logic [63:0] wr_addr;
        logic [4:0]  rd;
        logic [4:0]  control;
        logic        zero;
        logic        predictor;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        if_beq = 1'b0;
    logic [63:0] alu_val = '0;
    logic [63:0] wr_addr = '0;
    logic [4:0]  instruction_part = '0;
    logic [4:0]  control_in = '0;
    logic        zero_in = 1'b0;
    logic        predictor_val = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, if_beq_out, zero_out, predictor_out, mispredict_out;
    logic [63:0] alu_val_out, wr_addr_out;
    logic [4:0]  instruction_part_out, control_out;
    logic [15:0] mispredict_cnt;

    logic        s_in_ready, s_out_valid, s_if_beq_out, s_zero_out, s_predictor_out;
    logic        s_mispredict_out;
    logic [63:0] s_alu_val_out, s_wr_addr_out;
    logic [4:0]  s_instruction_part_out, s_control_out;
    logic [1:0]  s_mispredict_cnt;

    ex_mem_skid_stage u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .if_beq(if_beq), .alu_val(alu_val), .wr_addr(wr_addr),
        .instruction_part(instruction_part), .control_in(control_in), .zero_in(zero_in),
        .predictor_val(predictor_val), .out_valid(out_valid), .out_ready(out_ready),
        .if_beq_out(if_beq_out), .alu_val_out(alu_val_out), .wr_addr_out(wr_addr_out),
        .instruction_part_out(instruction_part_out), .control_out(control_out),
        .zero_out(zero_out), .predictor_out(predictor_out), .mispredict_out(mispredict_out),
        .mispredict_cnt(mispredict_cnt)
    );

    ex_mem_skid_stage #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .if_beq(if_beq), .alu_val(alu_val), .wr_addr(wr_addr),
        .instruction_part(instruction_part), .control_in(control_in), .zero_in(zero_in),
        .predictor_val(predictor_val), .out_valid(s_out_valid), .out_ready(out_ready),
        .if_beq_out(s_if_beq_out), .alu_val_out(s_alu_val_out), .wr_addr_out(s_wr_addr_out),
        .instruction_part_out(s_instruction_part_out), .control_out(s_control_out),
        .zero_out(s_zero_out), .predictor_out(s_predictor_out),
        .mispredict_out(s_mispredict_out), .mispredict_cnt(s_mispredict_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    bundle_t     sb[$];
    bundle_t     head, got, got_sat, nb;
    int unsigned exp_cnt = 0;
    int unsigned exp_sat = 0;
    logic        exp_mp, m_acc, m_ret;

    // Scoreboard: sample mid-cycle, then advance the model by the upcoming edge.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            exp_cnt = 0;
            exp_sat = 0;
        end else begin
            got = {if_beq_out, alu_val_out, wr_addr_out, instruction_part_out, control_out,
                   zero_out, predictor_out};
            got_sat = {s_if_beq_out, s_alu_val_out, s_wr_addr_out, s_instruction_part_out,
                       s_control_out, s_zero_out, s_predictor_out};
            head = (sb.size() > 0) ? sb[0] : '0;
            exp_mp = (sb.size() > 0) && head.if_beq && (head.zero ^ head.predictor);

            total++;
            if (in_ready !== (sb.size() < 2)) begin
                bad++;
                $display("FAIL sb_in_ready: got %b want %b", in_ready, (sb.size() < 2));
            end
            total++;
            if (out_valid !== (sb.size() > 0)) begin
                bad++;
                $display("FAIL sb_out_valid: got %b want %b", out_valid, (sb.size() > 0));
            end
            if (sb.size() > 0) begin
                total++;
                if (got !== head) begin
                    bad++;
                    $display("FAIL sb_payload: got %h want %h", got, head);
                end
            end
            total++;
            if (mispredict_out !== exp_mp) begin
                bad++;
                $display("FAIL sb_mispredict: got %b want %b", mispredict_out, exp_mp);
            end
            total++;
            if (mispredict_cnt !== 16'(exp_cnt)) begin
                bad++;
                $display("FAIL sb_cnt: got %0d want %0d", mispredict_cnt, exp_cnt);
            end
            total++;
            if (s_mispredict_cnt !== 2'(exp_sat)) begin
                bad++;
                $display("FAIL sb_sat_cnt: got %0d want %0d", s_mispredict_cnt, exp_sat);
            end
            total++;
            if ({s_in_ready, s_out_valid, s_mispredict_out, got_sat} !==
                {in_ready, out_valid, mispredict_out, got}) begin
                bad++;
                $display("FAIL sb_sat_agree: got %h want %h",
                         {s_in_ready, s_out_valid, s_mispredict_out, got_sat},
                         {in_ready, out_valid, mispredict_out, got});
            end

            m_acc = in_valid && (sb.size() < 2) && !flush;
            m_ret = (sb.size() > 0) && out_ready;
            nb = {if_beq, alu_val, wr_addr, instruction_part, control_in, zero_in, predictor_val};
            if (m_ret) begin
                if (exp_mp) begin
                    if (exp_cnt < 65535) exp_cnt++;
                    if (exp_sat < 3) exp_sat++;
                end
                void'(sb.pop_front());
            end
            if (flush) sb.delete();
            else if (m_acc) sb.push_back(nb);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic b, input logic [63:0] a,
                          input logic [4:0] c, input logic z, input logic p);
        in_valid         = v;
        if_beq           = b;
        alu_val          = a;
        wr_addr          = ~a;
        instruction_part = a[4:0];
        control_in       = c;
        zero_in          = z;
        predictor_val    = p;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++;
        if (mispredict_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", mispredict_cnt); end
        total++;
        if (alu_val_out !== 64'd0) begin bad++; $display("FAIL reset_alu: got %h want 0", alu_val_out); end
        total++;
        if (predictor_out !== 1'b0) begin bad++; $display("FAIL reset_pred: got %b want 0", predictor_out); end
        rst = 1'b1;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        set_in(1'b1, 1'b0, 64'd1, 5'd1, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid: got %b want 1", out_valid); end
            total++;
            if (alu_val_out !== 64'(i)) begin bad++; $display("FAIL stream_alu: got %0d want %0d", alu_val_out, i); end
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready: got %b want 1", in_ready); end
            alu_val = 64'(i + 1);
            wr_addr = ~alu_val;
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_in(1'b1, 1'b0, 64'hA, 5'd2, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 64'hB, 5'd2, 1'b0, 1'b0);
        tick();
        total++;
        if (alu_val_out !== 64'hA || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_full: got alu=%h rdy=%b want alu=a rdy=0", alu_val_out, in_ready);
        end
        set_in(1'b1, 1'b0, 64'hC, 5'd2, 1'b0, 1'b0);
        tick();
        total++;
        if (alu_val_out !== 64'hA || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold: got alu=%h rdy=%b want alu=a rdy=0", alu_val_out, in_ready);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (alu_val_out !== 64'hB || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_retire_a: got alu=%h rdy=%b want alu=b rdy=1", alu_val_out, in_ready);
        end
        tick();
        total++;
        if (alu_val_out !== 64'hC || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_c_in: got alu=%h vld=%b want alu=c vld=1", alu_val_out, out_valid);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_in(1'b1, 1'b0, 64'd1, 5'd5, 1'b0, 1'b1);
        tick();
        set_in(1'b1, 1'b0, 64'd2, 5'd5, 1'b0, 1'b1);
        tick();
        flush = 1'b1;
        set_in(1'b1, 1'b0, 64'hD, 5'd7, 1'b1, 1'b1);
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_valid: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
        total++;
        if (alu_val_out !== 64'd0 || control_out !== 5'd0 || wr_addr_out !== 64'd0) begin
            bad++;
            $display("FAIL flush_zero: got alu=%h ctl=%h wr=%h want 0", alu_val_out, control_out, wr_addr_out);
        end
        total++;
        if (predictor_out !== 1'b0) begin bad++; $display("FAIL flush_pred: got %b want 0", predictor_out); end
        // Flush while empty with in_ready=1: input dropped, predictor toggles again.
        set_in(1'b1, 1'b0, 64'hE, 5'd7, 1'b0, 1'b0);
        tick();
        total++;
        if (out_valid !== 1'b0 || predictor_out !== 1'b1) begin
            bad++;
            $display("FAIL flush_empty: got vld=%b pred=%b want vld=0 pred=1", out_valid, predictor_out);
        end
        flush = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            out_ready = ~out_ready;
            tick();
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL idle_toggle: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
            end
        end
    endtask

    task automatic test_mispredict();
        out_ready = 1'b1;
        set_in(1'b1, 1'b1, 64'h10, 5'd3, 1'b1, 1'b0);
        tick();
        total++;
        if (mispredict_out !== 1'b1) begin bad++; $display("FAIL mp_first: got %b want 1", mispredict_out); end
        set_in(1'b1, 1'b1, 64'h11, 5'd3, 1'b1, 1'b1);
        tick();
        total++;
        if (mispredict_out !== 1'b0 || mispredict_cnt !== 16'd1) begin
            bad++;
            $display("FAIL mp_correct: got mp=%b cnt=%0d want mp=0 cnt=1", mispredict_out, mispredict_cnt);
        end
        set_in(1'b1, 1'b0, 64'h12, 5'd3, 1'b1, 1'b0);
        tick();
        total++;
        if (mispredict_out !== 1'b0 || mispredict_cnt !== 16'd1) begin
            bad++;
            $display("FAIL mp_nonbranch: got mp=%b cnt=%0d want mp=0 cnt=1", mispredict_out, mispredict_cnt);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (mispredict_cnt !== 16'd1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mp_final: got cnt=%0d vld=%b want cnt=1 vld=0", mispredict_cnt, out_valid);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            set_in(1'b1, 1'b1, 64'(32 + k), 5'd4, 1'b1, 1'b0);
            tick();
            if (k >= 2) begin
                total++;
                if (s_mispredict_cnt !== 2'((k - 1) > 3 ? 3 : (k - 1)) || mispredict_cnt !== 16'(k - 1)) begin
                    bad++;
                    $display("FAIL sat_step: got sat=%0d cnt=%0d want sat=%0d cnt=%0d",
                             s_mispredict_cnt, mispredict_cnt, ((k - 1) > 3 ? 3 : (k - 1)), k - 1);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (s_mispredict_cnt !== 2'd3 || mispredict_cnt !== 16'd5) begin
            bad++;
            $display("FAIL sat_final: got sat=%0d cnt=%0d want sat=3 cnt=5", s_mispredict_cnt, mispredict_cnt);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        set_in(1'b1, 1'b1, 64'h30, 5'd3, 1'b1, 1'b1);
        tick();
        set_in(1'b1, 1'b1, 64'h31, 5'd3, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL ar_pre_full: got %b want 0", in_ready); end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || mispredict_out !== 1'b0) begin
            bad++;
            $display("FAIL ar_flags: got vld=%b rdy=%b mp=%b want 0 1 0", out_valid, in_ready, mispredict_out);
        end
        total++;
        if (alu_val_out !== 64'd0 || predictor_out !== 1'b0 || control_out !== 5'd0) begin
            bad++;
            $display("FAIL ar_payload: got alu=%h pred=%b ctl=%h want 0", alu_val_out, predictor_out, control_out);
        end
        total++;
        if (mispredict_cnt !== 16'd0 || s_mispredict_cnt !== 2'd0) begin
            bad++;
            $display("FAIL ar_cnt: got cnt=%0d sat=%0d want 0", mispredict_cnt, s_mispredict_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ar_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_mispredict();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid_stage.md
Name: ex_mem_skid_stage

Overview:
- Next-generation EX/MEM pipeline stage with a two-entry skid buffer and a valid/ready handshake on both sides.
- Lets EX keep issuing while MEM is stalled, without a combinational ready path from MEM back to EX.
- Adds registered branch-mispredict detection and a saturating mispredict counter for the branch predictor.
- Sits between the ALU/branch-compare logic (EX) and data-memory access (MEM).

Parameters:
- CONTROL_LINE, 5, width of the control bundle forwarded to MEM/WB.
- DATA_LEN, 64, width of the ALU result and the store-data/write-address word.
- INSTRUCTION_PART, 5, width of the destination-register field.
- CNT_W, 16, width of the mispredict counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush of all buffered entries.
- in_valid  in  1  EX presents a valid bundle.
- in_ready  out  1  stage can accept a bundle; registered.
- if_beq  in  1  bundle is a conditional branch.
- alu_val  in  DATA_LEN  ALU result.
- wr_addr  in  DATA_LEN  store data / address word.
- instruction_part  in  INSTRUCTION_PART  destination register.
- control_in  in  CONTROL_LINE  control bundle.
- zero_in  in  1  ALU zero flag (branch taken).
- predictor_val  in  1  predicted direction.
- out_valid  out  1  head entry valid toward MEM.
- out_ready  in  1  MEM accepts the head entry.
- if_beq_out, alu_val_out, wr_addr_out, instruction_part_out, control_out, zero_out, predictor_out  out  as inputs  head-entry payload.
- mispredict_out  out  1  head entry is a mispredicted branch.
- mispredict_cnt  out  CNT_W  count of retired mispredicts.

Behaviour:
- Storage:
  - Main entry M drives the outputs directly; skid entry S holds overflow. Each entry has its own valid bit.
  - State encoding: EMPTY (M=0, S=0), ONE (M=1, S=0), FULL (M=1, S=1).
- Handshakes:
  - acc = in_valid & in_ready.
  - ret = out_valid & out_ready.
  - out_valid = M valid.
  - in_ready = ~S valid, taken from a flop.
- Transitions (no flush):
  - EMPTY: acc moves data into M → ONE.
  - ONE: acc&ret reloads M → ONE; acc&~ret loads S → FULL; ~acc&ret → EMPTY; otherwise hold.
  - FULL: ret moves S into M → ONE; otherwise hold. acc is impossible because in_ready=0.
- Latency: 1 cycle from input handshake to out_valid when the stage is EMPTY or draining.
- Throughput: one bundle per cycle with out_ready held high.
- Ordering: strictly FIFO; S is never bypassed.
- Payload must not change while out_valid=1 and out_ready=0.
- Flush (synchronous, highest priority after reset):
  - Both valid bits clear → EMPTY, in_ready=1 on the next cycle.
  - M payload and S payload zeroed, except predictor_out, which inverts its current value (legacy predictor-toggle behaviour retained).
  - An input presented in the flush cycle is discarded even if in_ready=1.
  - A retire in the flush cycle still counts toward mispredict_cnt.
- Mispredict:
  - mispredict_out = out_valid & if_beq_out & (zero_out ^ predictor_out), derived purely from registers.
  - mispredict_cnt increments by 1 on each ret with mispredict_out=1.
  - Saturates at all-ones with no wrap.
  - flush does not clear it.
- Reset (rst=0, async, any cycle including mid-transfer):
  - All payload, valid bits, predictor_out and mispredict_cnt go to 0.
  - in_ready goes to 1; out_valid and mispredict_out go to 0.
  - On release, the stage is in EMPTY.
- Boundary conditions:
  - Simultaneous acc and ret in ONE keeps the stage in ONE with the new data in M.
  - out_ready toggling with out_valid=0 has no effect.
  - Counter at max with another mispredict retire stays at max.

Test Plan:
- Reset then stream: rst low 3 cycles; then in_valid=1, out_ready=1, alu_val=1,2,3… each cycle.
  - Required: out_valid rises 1 cycle after the first accept; alu_val_out = 1,2,3 on consecutive cycles; in_ready stays 1.
- Backpressure: out_ready=0 while pushing alu_val=0xA, 0xB.
  - Required: M=0xA, S=0xB, in_ready=0 the cycle after the second accept; 0xC is held off.
  - Required: raising out_ready retires 0xA then 0xB in order, and in_ready returns to 1 one cycle after 0xA retires.
- Flush in FULL: predictor_out=1, flush=1, in_valid=1 with alu_val=0xD.
  - Required: next cycle out_valid=0, in_ready=1, alu_val_out=0, control_out=0, predictor_out=0; 0xD never appears.
- Mispredict count: retire if_beq=1, zero_in=1, predictor_val=0; then retire a correctly predicted branch; then retire a non-branch with zero≠pred.
  - Required: mispredict_out=1 only for the first; mispredict_cnt=1.
- Saturation: CNT_W=2, retire 5 mispredicted branches.
  - Required: mispredict_cnt = 1,2,3,3,3.
- Async reset mid-FULL: drop rst between clock edges.
  - Required: outputs zero immediately without waiting for clk; in_ready=1; mispredict_cnt=0.
